// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - I2C controller for single-register write/read transactions
// Optional: define I2C_CLK_STRETCH_EN to honour target clock stretching via scl_in.
module i2c_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk100,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [7:0] rdata
);

    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK1, REG, ACK2, WDATA, ACK3,
        RSTART, ADDR_R, RDATA, MNACK, STOP, DONE
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [1:0]      qtr;
    logic [2:0]      bitn;
    logic            rw_q;
    logic [6:0]      dev_q;
    logic [7:0]      reg_q;
    logic [7:0]      wdata_q;
    logic [7:0]      rx;
    logic [7:0]      tx_byte;
    logic [1:0]      sda_sync;
    logic            sda_s;
    logic            active;
    logic            hold;
    logic            quarter_end;
    logic            phase_end;

    assign sda_s  = sda_sync[1];
    assign active = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk100) begin
        if (!reset_n) sda_sync <= 2'b11;
        else          sda_sync <= {sda_sync[0], sda_in};
    end

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_sync;
    logic       stretch_ph;

    always_ff @(posedge clk100) begin
        if (!reset_n) scl_sync <= 2'b11;
        else          scl_sync <= {scl_sync[0], scl_in};
    end

    // Released-SCL quarters wait at tick 0 until the line is actually seen high.
    assign stretch_ph = !(state inside {IDLE, START, DONE});
    assign hold       = stretch_ph && qtr[1] && (cnt == '0) && !scl_sync[1];
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign hold       = 1'b0;
`endif

    assign quarter_end = active && !hold && (cnt == CW'(CLK_DIV - 1));
    assign phase_end   = quarter_end && (qtr == 2'd3);

    always_ff @(posedge clk100) begin
        if (!reset_n || !active) begin
            cnt <= '0;
            qtr <= 2'd0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (quarter_end) begin
            cnt <= '0;
            qtr <= qtr + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            rw_q    <= 1'b0;
            dev_q   <= 7'd0;
            reg_q   <= 8'd0;
            wdata_q <= 8'd0;
            rx      <= 8'd0;
            rdata   <= 8'd0;
            nack    <= 1'b0;
            bitn    <= 3'd7;
        end else begin
            if (state == IDLE && cmd_valid) begin
                rw_q    <= cmd_rw;
                dev_q   <= cmd_dev;
                reg_q   <= cmd_reg;
                wdata_q <= cmd_wdata;
                nack    <= 1'b0;
                bitn    <= 3'd7;
            end
            // bitn wraps 0 -> 7 at the end of each byte, ready for the next one.
            if (phase_end) begin
                case (state)
                    ADDR_W, REG, WDATA, ADDR_R: bitn <= bitn - 3'd1;
                    RDATA: begin
                        bitn <= bitn - 3'd1;
                        rx   <= {rx[6:0], sda_s};
                        if (bitn == 3'd0) rdata <= {rx[6:0], sda_s};
                    end
                    ACK1, ACK2, ACK3: if (sda_s) nack <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        scl_oe   = 1'b0;
        sda_oe   = 1'b0;
        busy     = active;
        done     = 1'b0;
        tx_byte  = 8'd0;
        case (state)
            ADDR_W:  tx_byte = {dev_q, 1'b0};
            ADDR_R:  tx_byte = {dev_q, 1'b1};
            REG:     tx_byte = reg_q;
            WDATA:   tx_byte = wdata_q;
            default: tx_byte = 8'd0;
        endcase
        case (state)
            IDLE: if (cmd_valid) state_nx = START;
            START: begin
                sda_oe = qtr[1];
                scl_oe = (qtr == 2'd3);
                if (phase_end) state_nx = ADDR_W;
            end
            ADDR_W, REG, WDATA, ADDR_R: begin
                scl_oe = ~qtr[1];
                sda_oe = ~tx_byte[bitn];
                if (phase_end && bitn == 3'd0) begin
                    case (state)
                        ADDR_W:  state_nx = ACK1;
                        REG:     state_nx = ACK2;
                        default: state_nx = ACK3;
                    endcase
                end
            end
            RDATA: begin
                scl_oe = ~qtr[1];
                if (phase_end && bitn == 3'd0) state_nx = MNACK;
            end
            ACK1, ACK2, ACK3: begin
                scl_oe = ~qtr[1];
                if (phase_end) begin
                    if (sda_s)               state_nx = STOP;
                    else if (state == ACK1)  state_nx = REG;
                    else if (state == ACK2)  state_nx = rw_q ? RSTART : WDATA;
                    else                     state_nx = rw_q ? RDATA : STOP;
                end
            end
            MNACK: begin
                scl_oe = ~qtr[1];
                if (phase_end) state_nx = STOP;
            end
            RSTART: begin
                scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
                sda_oe = qtr[1];
                if (phase_end) state_nx = ADDR_R;
            end
            STOP: begin
                scl_oe = ~qtr[1];
                sda_oe = (qtr != 2'd3);
                if (phase_end) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - randomized self-checking bench for i2c_master with bus target model
module tb_i2c_master;

    localparam int CLK_DIV = 4;

    logic       clk100 = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev = 7'd0;
    logic [7:0] cmd_reg = 8'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       scl_in, sda_in;
    logic       scl_oe, sda_oe, busy, done, nack;
    logic [7:0] rdata;

    logic tgt_pull = 1'b0;
    logic str_hold = 1'b0;

    assign scl_in = ~scl_oe & ~str_hold;
    assign sda_in = ~sda_oe & ~tgt_pull;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk100(clk100), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .cmd_dev(cmd_dev),
        .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .scl_in(scl_in), .sda_in(sda_in),
        .scl_oe(scl_oe), .sda_oe(sda_oe),
        .busy(busy), .done(done), .nack(nack), .rdata(rdata)
    );

    always #5 clk100 = ~clk100;

    int n_checks = 0;
    int n_errors = 0;

    // Bus events: 0/1 = bit clocked, 2 = START, 3 = STOP.
    int   ev_q[$];
    int   exp_q[$];
    logic prev_scl = 1'b1, prev_sda = 1'b1;
    logic pend = 1'b0, pend_val = 1'b0;
    int   nb = 0, seg = 0, nack_at = 3, hcnt = 0;
    logic [7:0] tgt_rbyte = 8'd0;
    bit   stretch_arm = 1'b0;

    int   model_rdata = 0;
    int   exp_nack = 0;
    int   last_lat = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic want_pull(input int n);
        int byte_i, pos, slot;
        byte_i = n / 9;
        pos    = n % 9;
        if (seg == 2 && byte_i == 1 && pos < 8) return ~tgt_rbyte[7 - pos];
        if (pos == 8 && (seg == 1 || byte_i == 0)) begin
            slot = (seg == 1) ? byte_i : 2;
            return slot != nack_at;
        end
        return 1'b0;
    endfunction

    // Target + bus monitor; a rise is committed as a bit only at the next fall.
    always @(negedge clk100) begin
        logic cs, cd;
        cs = scl_in;
        cd = sda_in;
        if (prev_scl && cs && prev_sda && !cd) begin
            ev_q.push_back(2); pend = 1'b0; seg++; nb = 0; tgt_pull = 1'b0;
        end else if (prev_scl && cs && !prev_sda && cd) begin
            ev_q.push_back(3); pend = 1'b0; seg = 0; nb = 0; tgt_pull = 1'b0;
        end
        if (!prev_scl && cs) begin
            pend = 1'b1; pend_val = cd; nb++;
        end
        if (prev_scl && !cs) begin
            if (pend) ev_q.push_back(int'(pend_val));
            pend = 1'b0;
            tgt_pull = want_pull(nb);
            if (stretch_arm && seg == 1 && nb == 9) begin
                str_hold = 1'b1; hcnt = 0; stretch_arm = 1'b0;
            end
        end
        if (str_hold && !scl_oe) begin
            hcnt++;
            if (hcnt >= 20) str_hold = 1'b0;
        end
        prev_scl = cs;
        prev_sda = cd;
    end

    function automatic void push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(int'(b[i]));
    endfunction

    // Expected bus sequence from the transaction rules; nk = ACK slot the target refuses.
    function automatic void build_exp(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                                      input logic [7:0] wd, input logic [7:0] rb, input int nk);
        exp_q.delete();
        exp_nack = 1;
        exp_q.push_back(2);
        push_byte({dev, 1'b0});
        if (nk == 0) begin exp_q.push_back(1); exp_q.push_back(3); return; end
        exp_q.push_back(0);
        push_byte(rg);
        if (nk == 1) begin exp_q.push_back(1); exp_q.push_back(3); return; end
        exp_q.push_back(0);
        if (!rw) begin
            push_byte(wd);
            exp_q.push_back(nk == 2 ? 1 : 0);
            exp_q.push_back(3);
            exp_nack = (nk == 2) ? 1 : 0;
        end else begin
            exp_q.push_back(2);
            push_byte({dev, 1'b1});
            if (nk == 2) begin exp_q.push_back(1); exp_q.push_back(3); return; end
            exp_q.push_back(0);
            push_byte(rb);
            exp_q.push_back(1);
            exp_q.push_back(3);
            exp_nack = 0;
            model_rdata = int'(rb);
        end
    endfunction

    task automatic clear_mon();
        ev_q.delete();
        seg = 0; nb = 0; pend = 1'b0; tgt_pull = 1'b0;
    endtask

    task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] rb, input int nk, input int poke);
        int n, got, lim;
        @(posedge clk100); #1;
        check("idle_done", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        clear_mon();
        nack_at   = nk;
        tgt_rbyte = rb;
        build_exp(rw, dev, rg, wd, rb, nk);
        cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
        n = 0; got = 0;
        while (n < 4000) begin
            @(posedge clk100); n++; #1;
            if (n == 1) begin
                cmd_valid = 1'b0;
                check("accept_busy", int'(busy), 1);
                check("accept_nack", int'(nack), 0);
            end
            if (n == poke) begin
                cmd_valid = 1'b1; cmd_rw = ~rw; cmd_dev = ~dev; cmd_reg = ~rg; cmd_wdata = ~wd;
            end
            if (n == poke + 1) cmd_valid = 1'b0;
            @(negedge clk100);
            if (done) begin got = 1; break; end
        end
        check("done_seen", got, 1);
        last_lat = n;
`ifndef I2C_CLK_STRETCH_EN
        check("latency", n, exp_q.size() * 4 * CLK_DIV + 1);
`endif
        check("done_busy", int'(busy), 0);
        check("nack", int'(nack), exp_nack);
        check("rdata", int'(rdata), model_rdata);
        check("seq_len", ev_q.size(), exp_q.size());
        lim = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) check($sformatf("seq[%0d]", i), ev_q[i], exp_q[i]);
    endtask

    task automatic reset_mid_reg();
        int n;
        @(posedge clk100); #1;
        clear_mon();
        nack_at = 3; tgt_rbyte = 8'h77;
        cmd_rw = 1'b1; cmd_dev = 7'h2A; cmd_reg = 8'h40; cmd_wdata = 8'h00; cmd_valid = 1'b1;
        @(posedge clk100); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (ev_q.size() < 14 && n < 2000) begin
            @(negedge clk100); n++;
        end
        check("reg_byte_reached", int'(ev_q.size() >= 14), 1);
        @(posedge clk100); #1;
        reset_n = 1'b0; tgt_pull = 1'b0;
        @(posedge clk100); #1;
        check("rst_scl_oe", int'(scl_oe), 0);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rdata", int'(rdata), 0);
        reset_n = 1'b1;
        model_rdata = 0;
        repeat (4) @(posedge clk100);
    endtask

    initial begin
        repeat (3) @(posedge clk100);
        #1;
        check("reset_scl_oe", int'(scl_oe), 0);
        check("reset_sda_oe", int'(sda_oe), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_nack", int'(nack), 0);
        check("reset_rdata", int'(rdata), 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk100);

        run_cmd(1'b0, 7'h2A, 8'h05, 8'hA5, 8'h00, 3, 0);
        run_cmd(1'b0, 7'h11, 8'h00, 8'h33, 8'h00, 0, 0);
        run_cmd(1'b1, 7'h2A, 8'h1F, 8'h00, 8'h3C, 3, 0);
        run_cmd(1'b0, 7'h33, 8'h44, 8'h55, 8'h00, 3, 100);
        run_cmd(1'b1, 7'h2A, 8'h10, 8'h00, 8'h99, 3, 0);

        reset_mid_reg();
        run_cmd(1'b0, 7'h2A, 8'h06, 8'h5A, 8'h00, 3, 0);

        for (int k = 0; k < 8; k++) begin
            run_cmd(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), int'($urandom_range(0, 5)), 0);
        end

`ifdef I2C_CLK_STRETCH_EN
        begin
            int base;
            run_cmd(1'b0, 7'h2A, 8'h05, 8'hA5, 8'h00, 3, 0);
            base = last_lat;
            stretch_arm = 1'b1;
            run_cmd(1'b0, 7'h2A, 8'h05, 8'hA5, 8'h00, 3, 0);
            check("stretch_delay", int'((last_lat - base) >= 18 && (last_lat - base) <= 22), 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
